// File: rtl/prefetch_fill_buffer.sv
// rtl/prefetch_fill_buffer.sv - line-read path with one-entry next-line prefetch buffer
//
// Sits between the last-level cache miss port and physical memory. Line
// writes pass straight through; line reads are fetched from memory, and after
// every read the next sequential line is prefetched into a one-entry buffer so
// a streaming miss completes in one cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   mem_address/mem_read/mem_write/mem_wdata   cache-side request
//   mem_rdata/mem_resp            cache-side response (one-cycle pulse)
//   pmem_address/pmem_read/pmem_write/pmem_wdata  memory-side request
//   pmem_rdata/pmem_resp          memory-side response
module prefetch_fill_buffer #(
    parameter int s_offset    = 5,
    parameter int s_line      = 256,
    parameter bit prefetch_en = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_rdata,
    input  logic [s_line-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    output logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_rdata,
    output logic [s_line-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        FETCH,
        WRITE,
        RESP,
        PREFETCH
    } state_t;

    localparam logic [31:0] line_bytes = 32'(2 ** s_offset);

    state_t            state;
    logic              buf_valid;
    logic [31:0]       buf_tag;
    logic [s_line-1:0] buf_data;
    logic [s_line-1:0] rdata_reg;
    logic [31:0]       line_reg;   // line of the request being serviced
    logic              was_read;   // RESP follows a read (prefetch) or a write (idle)

    logic [31:0] req_line;
    logic [31:0] next_line;
    logic        buf_hit;
    logic        unused_low_bits;

    assign req_line        = {mem_address[31:s_offset], {s_offset{1'b0}}};
    assign next_line       = line_reg + line_bytes;   // wraps modulo 2^32
    assign buf_hit         = buf_valid && (buf_tag == req_line);
    assign unused_low_bits = ^mem_address[s_offset-1:0];
    assign mem_rdata       = rdata_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            buf_data     <= '0;
            rdata_reg    <= '0;
            line_reg     <= '0;
            was_read     <= 1'b0;
            mem_resp     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            // mem_resp is only ever raised on the edge entering HIT or RESP,
            // so it can never stay high for two cycles.
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        line_reg     <= req_line;
                        pmem_address <= req_line;
                        pmem_wdata   <= mem_wdata;
                        pmem_write   <= 1'b1;
                        was_read     <= 1'b0;
                        // a buffered copy of this line would now be stale
                        if (buf_hit) buf_valid <= 1'b0;
                        state        <= WRITE;
                    end else if (mem_read) begin
                        line_reg <= req_line;
                        was_read <= 1'b1;
                        if (buf_hit) begin
                            rdata_reg <= buf_data;
                            buf_valid <= 1'b0;
                            mem_resp  <= 1'b1;
                            state     <= HIT;
                        end else begin
                            pmem_address <= req_line;
                            pmem_read    <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                HIT: begin
                    if (prefetch_en) begin
                        pmem_address <= next_line;
                        pmem_read    <= 1'b1;
                        state        <= PREFETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        rdata_reg <= pmem_rdata;
                        pmem_read <= 1'b0;
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    if (pmem_resp) begin
                        pmem_write <= 1'b0;
                        mem_resp   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (was_read && prefetch_en) begin
                        pmem_address <= next_line;
                        pmem_read    <= 1'b1;
                        state        <= PREFETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREFETCH: begin
                    // pmem_address still holds the prefetch line here
                    if (pmem_resp) begin
                        buf_data  <= pmem_rdata;
                        buf_tag   <= pmem_address;
                        buf_valid <= 1'b1;
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_fill_buffer.sv
// tb/tb_prefetch_fill_buffer.sv - randomized self-checking bench for prefetch_fill_buffer
module tb_prefetch_fill_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [255:0] mem_rdata;
    logic [255:0] mem_wdata = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = '0;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp = 1'b0;

    // second instance with prefetching disabled
    logic [31:0]  p0_mem_address = '0;
    logic [255:0] p0_mem_rdata;
    logic         p0_mem_read = 1'b0;
    logic         p0_mem_resp;
    logic [31:0]  p0_pmem_address;
    logic [255:0] p0_pmem_rdata = '0;
    logic [255:0] p0_pmem_wdata;
    logic         p0_pmem_read;
    logic         p0_pmem_write;
    logic         p0_pmem_resp = 1'b0;

    always #5 clk = ~clk;

    prefetch_fill_buffer #(.s_offset(5), .s_line(256), .prefetch_en(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_address(mem_address), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    prefetch_fill_buffer #(.s_offset(5), .s_line(256), .prefetch_en(1'b0)) dut_nopf (
        .clk(clk), .rst(rst), .mem_address(p0_mem_address), .mem_rdata(p0_mem_rdata),
        .mem_wdata(256'd0), .mem_read(p0_mem_read), .mem_write(1'b0), .mem_resp(p0_mem_resp),
        .pmem_address(p0_pmem_address), .pmem_rdata(p0_pmem_rdata), .pmem_wdata(p0_pmem_wdata),
        .pmem_read(p0_pmem_read), .pmem_write(p0_pmem_write), .pmem_resp(p0_pmem_resp)
    );

    int passed = 0;
    int total  = 0;

    // ---------------- memory model and transaction log ----------------
    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } tx_t;

    tx_t          txq[$];
    logic [255:0] mem_q[logic [31:0]];
    int           fixed_lat = -1;

    function automatic logic [255:0] exp_line(input logic [31:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return {4{a, ~a}};
    endfunction

    // responder for the main instance: random (or fixed) latency, logs every transaction
    initial begin
        bit busy;
        int left;
        busy = 1'b0;
        left = 0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!rst || !(pmem_read || pmem_write)) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    txq.push_back('{pmem_write, pmem_address, pmem_wdata});
                end
                if (left == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) mem_q[pmem_address] = pmem_wdata;
                    else pmem_rdata = exp_line(pmem_address);
                    busy = 1'b0;
                end else begin
                    left--;
                end
            end
        end
    end

    // responder for the non-prefetching instance: fixed one-cycle latency
    int          p0_reads = 0;
    logic [31:0] p0_last_addr = '0;
    initial begin
        bit busy;
        busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            p0_pmem_resp = 1'b0;
            if (!rst || !p0_pmem_read) begin
                busy = 1'b0;
            end else if (!busy) begin
                busy = 1'b1;
                p0_reads++;
                p0_last_addr = p0_pmem_address;
            end else begin
                p0_pmem_resp  = 1'b1;
                p0_pmem_rdata = exp_line(p0_pmem_address);
                busy = 1'b0;
            end
        end
    end

    // prefetch buffer model: after each read the next line is buffered
    bit          m_valid = 1'b0;
    logic [31:0] m_tag   = '0;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_read(input logic [31:0] a, output logic [255:0] d, output int cyc, output int ntx);
        txq.delete();
        @(posedge clk); #1;
        mem_address = a;
        mem_read = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_resp || cyc > 100) break;
        end
        d   = (cyc > 100) ? 'x : mem_rdata;
        ntx = txq.size();
        mem_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] w, output int cyc, output int ntx);
        txq.delete();
        @(posedge clk); #1;
        mem_address = a;
        mem_wdata = w;
        mem_write = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_resp || cyc > 100) break;
        end
        ntx = (cyc > 100) ? -1 : txq.size();
        mem_write = 1'b0;
    endtask

    // wait until memory traffic has stopped for several cycles
    task automatic settle();
        int quiet = 0;
        for (int i = 0; i < 200 && quiet < 4; i++) begin
            @(posedge clk); #1;
            quiet = (pmem_read || pmem_write) ? 0 : quiet + 1;
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_resp, pmem_read, pmem_write} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {mem_resp, pmem_read, pmem_write});
        else passed++;
        total++;
        if (mem_rdata !== '0 || pmem_wdata !== '0) $display("FAIL reset_data got rdata=%h wdata=%h want 0", mem_rdata, pmem_wdata);
        else passed++;
        total++;
        if (pmem_address !== 32'h0) $display("FAIL reset_addr got %h want 0", pmem_address);
        else passed++;
        rst = 1'b1;
        m_valid = 1'b0;
    endtask

    task automatic test_cold_read();
        logic [255:0] d;
        int cyc, ntx;
        fixed_lat = 3;
        do_read(32'h0000_1234, d, cyc, ntx);
        total++;
        if (ntx != 1 || txq[0].wr || txq[0].addr !== 32'h0000_1220) $display("FAIL cold_fetch got ntx=%0d addr=%h want 1 read of 00001220", ntx, (ntx > 0) ? txq[0].addr : 32'hx);
        else passed++;
        total++;
        if (d !== exp_line(32'h0000_1220)) $display("FAIL cold_data got %h want %h", d, exp_line(32'h0000_1220));
        else passed++;
        @(posedge clk); #1;
        total++;
        if (mem_resp !== 1'b0) $display("FAIL cold_resp_pulse got %b want 0", mem_resp);
        else passed++;
        settle();
        total++;
        if (txq.size() != 2 || txq[1].wr || txq[1].addr !== 32'h0000_1240) $display("FAIL cold_prefetch got n=%0d want read of 00001240", txq.size());
        else passed++;
        m_valid = 1'b1;
        m_tag = 32'h0000_1240;
        fixed_lat = -1;
    endtask

    task automatic test_streaming();
        logic [255:0] d;
        int cyc, ntx;
        do_read(32'h0000_1248, d, cyc, ntx);
        total++;
        if (cyc != 1 || ntx != 0) $display("FAIL stream_hit got latency=%0d pmem_tx=%0d want 1 and 0", cyc, ntx);
        else passed++;
        total++;
        if (d !== exp_line(32'h0000_1240)) $display("FAIL stream_data got %h want %h", d, exp_line(32'h0000_1240));
        else passed++;
        settle();
        total++;
        if (txq.size() != 1 || txq[0].addr !== 32'h0000_1260) $display("FAIL stream_prefetch got n=%0d want read of 00001260", txq.size());
        else passed++;
        m_tag = 32'h0000_1260;
    endtask

    task automatic test_write_inval();
        logic [255:0] d, c;
        int cyc, ntx;
        c = rand_line();
        do_write(32'h0000_1264, c, cyc, ntx);
        total++;
        if (ntx != 1 || !txq[0].wr || txq[0].addr !== 32'h0000_1260 || txq[0].data !== c) $display("FAIL write_pass got ntx=%0d want 1 write of 00001260", ntx);
        else passed++;
        m_valid = 1'b0;
        settle();
        do_read(32'h0000_1260, d, cyc, ntx);
        total++;
        if (ntx != 1 || txq[0].addr !== 32'h0000_1260) $display("FAIL write_inval_miss got pmem_tx=%0d want 1", ntx);
        else passed++;
        total++;
        if (d !== c) $display("FAIL write_readback got %h want %h", d, c);
        else passed++;
        settle();
        m_valid = 1'b1;
        m_tag = 32'h0000_1280;
    endtask

    task automatic test_wrap();
        logic [255:0] d;
        int cyc, ntx;
        do_read(32'hFFFF_FFF0, d, cyc, ntx);
        total++;
        if (ntx != 1 || txq[0].addr !== 32'hFFFF_FFE0) $display("FAIL wrap_fetch got ntx=%0d want read of ffffffe0", ntx);
        else passed++;
        settle();
        total++;
        if (txq.size() != 2 || txq[1].addr !== 32'h0000_0000) $display("FAIL wrap_prefetch got n=%0d want read of 00000000", txq.size());
        else passed++;
        do_read(32'h0000_0004, d, cyc, ntx);
        total++;
        if (cyc != 1 || ntx != 0 || d !== exp_line(32'h0)) $display("FAIL wrap_hit got latency=%0d pmem_tx=%0d want 1 and 0", cyc, ntx);
        else passed++;
        settle();
        m_valid = 1'b1;
        m_tag = 32'h0000_0020;
    endtask

    task automatic test_rw_priority();
        logic [255:0] w;
        int cyc;
        w = rand_line();
        txq.delete();
        @(posedge clk); #1;
        mem_address = 32'h0000_2000;
        mem_wdata = w;
        mem_read = 1'b1;
        mem_write = 1'b1;
        cyc = 0;
        while (!mem_resp && cyc <= 100) begin @(posedge clk); #1; cyc++; end
        total++;
        if (cyc > 100 || txq.size() != 1 || !txq[0].wr) $display("FAIL rw_write_first got n=%0d want 1 write", txq.size());
        else passed++;
        mem_write = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_resp !== 1'b0) $display("FAIL rw_single_pulse got %b want 0", mem_resp);
        else passed++;
        cyc = 0;
        while (!mem_resp && cyc <= 100) begin @(posedge clk); #1; cyc++; end
        total++;
        if (cyc > 100 || txq.size() != 2 || txq[1].wr || txq[1].addr !== 32'h0000_2000 || mem_rdata !== w) $display("FAIL rw_read_after got n=%0d rdata=%h want %h", txq.size(), mem_rdata, w);
        else passed++;
        mem_read = 1'b0;
        settle();
        m_valid = 1'b1;
        m_tag = 32'h0000_2020;
    endtask

    task automatic test_reset_mid_fetch();
        logic [255:0] d;
        int cyc, ntx;
        logic [31:0] old_tag;
        old_tag = m_tag;
        fixed_lat = 20;
        @(posedge clk); #1;
        mem_address = 32'h0000_5000;
        mem_read = 1'b1;
        cyc = 0;
        while (!pmem_read && cyc <= 20) begin @(posedge clk); #1; cyc++; end
        #2 rst = 1'b0;
        #1;
        total++;
        if (cyc > 20 || {mem_resp, pmem_read, pmem_write} !== 3'b000 || pmem_address !== 32'h0 || mem_rdata !== '0)
            $display("FAIL async_reset got ctrl=%b addr=%h want 000 and 0", {mem_resp, pmem_read, pmem_write}, pmem_address);
        else passed++;
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fixed_lat = -1;
        m_valid = 1'b0;
        do_read(old_tag + 32'h4, d, cyc, ntx);
        total++;
        if (ntx != 1 || txq[0].addr !== old_tag || d !== exp_line(old_tag)) $display("FAIL reset_clears_buf got pmem_tx=%0d want 1 (miss)", ntx);
        else passed++;
        settle();
        m_valid = 1'b1;
        m_tag = old_tag + 32'h20;
    endtask

    task automatic test_random();
        logic [255:0] d, w;
        logic [31:0] a, ln;
        int cyc, ntx;
        bit hit;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0 && m_valid) a = m_tag + 32'($urandom_range(0, 31));
            else a = 32'h0000_4000 + 32'($urandom_range(0, 5) << 5) + 32'($urandom_range(0, 31));
            ln = line_of(a);
            if ($urandom_range(0, 3) == 0) begin
                w = rand_line();
                do_write(a, w, cyc, ntx);
                total++;
                if (ntx != 1 || !txq[0].wr || txq[0].addr !== ln || txq[0].data !== w) $display("FAIL rand_write[%0d] got ntx=%0d want 1 write of %h", i, ntx, ln);
                else passed++;
                if (m_valid && m_tag == ln) m_valid = 1'b0;
                settle();
            end else begin
                hit = m_valid && (m_tag == ln);
                do_read(a, d, cyc, ntx);
                total++;
                if (d !== exp_line(ln)) $display("FAIL rand_data[%0d] got %h want %h", i, d, exp_line(ln));
                else passed++;
                total++;
                if (hit ? (cyc != 1 || ntx != 0) : (ntx != 1 || txq[0].wr || txq[0].addr !== ln))
                    $display("FAIL rand_hitmiss[%0d] got latency=%0d pmem_tx=%0d want hit=%0d", i, cyc, ntx, hit);
                else passed++;
                settle();
                total++;
                if (txq.size() == 0 || txq[txq.size()-1].wr || txq[txq.size()-1].addr !== ln + 32'h20)
                    $display("FAIL rand_prefetch[%0d] got n=%0d want read of %h", i, txq.size(), ln + 32'h20);
                else passed++;
                m_valid = 1'b1;
                m_tag = ln + 32'h20;
            end
        end
    endtask

    task automatic test_no_prefetch();
        int cyc;
        @(posedge clk); #1;
        p0_reads = 0;
        p0_mem_address = 32'h0000_3000;
        p0_mem_read = 1'b1;
        cyc = 0;
        while (!p0_mem_resp && cyc <= 100) begin @(posedge clk); #1; cyc++; end
        total++;
        if (cyc > 100 || p0_mem_rdata !== exp_line(32'h0000_3000) || p0_reads != 1) $display("FAIL nopf_read got reads=%0d rdata=%h", p0_reads, p0_mem_rdata);
        else passed++;
        p0_mem_read = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (p0_reads != 1 || p0_pmem_read !== 1'b0) $display("FAIL nopf_no_prefetch got reads=%0d want 1", p0_reads);
        else passed++;
        p0_mem_address = 32'h0000_3020;
        p0_mem_read = 1'b1;
        cyc = 0;
        while (!p0_mem_resp && cyc <= 100) begin @(posedge clk); #1; cyc++; end
        total++;
        if (cyc > 100 || p0_reads != 2 || p0_last_addr !== 32'h0000_3020 || p0_mem_rdata !== exp_line(32'h0000_3020))
            $display("FAIL nopf_next_miss got reads=%0d addr=%h want 2 and 00003020", p0_reads, p0_last_addr);
        else passed++;
        p0_mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_streaming();
        test_write_inval();
        test_wrap();
        test_rw_priority();
        test_reset_mid_fetch();
        test_random();
        test_no_prefetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/prefetch_fill_buffer.md
Name: prefetch_fill_buffer

Overview:
- Read-side counterpart to the writeback/eviction path. Sits between the last-level cache's line-miss port and physical memory.
- Services 256-bit line reads from pmem and passes line writes straight through.
- After every read it fetches the next sequential line into a one-entry buffer, so streaming misses hit in one cycle.

Parameters:
s_offset, 5, byte-offset bits per line; the line is 2**s_offset bytes.
s_line, 256, line width in bits (8*2**s_offset).
prefetch_en, 1, 1 = fetch the next line after each read; 0 = never prefetch (the buffer stays invalid).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
mem_address  input  32  cache-side line address; low s_offset bits ignored
mem_rdata  output  s_line  read line returned to the cache
mem_wdata  input  s_line  writeback line from the cache
mem_read  input  1  line read request; held until mem_resp
mem_write  input  1  line write request; held until mem_resp
mem_resp  output  1  one-cycle completion pulse
pmem_address  output  32  physical address; low s_offset bits always 0
pmem_rdata  input  s_line  line data from memory, valid with pmem_resp
pmem_wdata  output  s_line  line data to memory
pmem_read  output  1  memory read request; held until pmem_resp
pmem_write  output  1  memory write request; held until pmem_resp
pmem_resp  input  1  memory completion pulse

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; buf_valid=0; buf_tag=0; buf_data=0; rdata_reg=0.
  - All outputs are 0: mem_resp, pmem_read, pmem_write, mem_rdata, pmem_address, pmem_wdata.
  - An in-flight pmem transaction is abandoned; memory must tolerate the dropped request.
- Line address: line = {mem_address[31:s_offset], s_offset'b0}. Next line = line + 2**s_offset, modulo 2^32, so 0xFFFFFFE0 wraps to 0x00000000.
- FSM states: IDLE, HIT, FETCH, WRITE, RESP, PREFETCH.
- IDLE:
  - mem_write has priority over mem_read when both are asserted.
  - On mem_write: latch line address and mem_wdata, go to WRITE. If buf_valid and buf_tag==line, clear buf_valid in the same edge.
  - On mem_read with buf_valid and buf_tag==line (hit): rdata_reg<=buf_data, buf_valid<=0, go to HIT.
  - On mem_read otherwise (miss): latch line address, go to FETCH.
- HIT: mem_resp=1 for one cycle. Next state is PREFETCH of line+32 if prefetch_en, else IDLE.
  - Hit latency: request sampled at edge N, mem_resp high in the cycle after N.
- FETCH:
  - pmem_read=1, pmem_address=line.
  - On pmem_resp: rdata_reg<=pmem_rdata, go to RESP.
- WRITE:
  - pmem_write=1, pmem_address=line, pmem_wdata=latched data.
  - On pmem_resp: go to RESP.
- RESP: mem_resp=1 for exactly one cycle.
  - After a read: next state is PREFETCH if prefetch_en, else IDLE.
  - After a write: next state is IDLE.
- PREFETCH:
  - pmem_read=1, pmem_address=pf_addr (previous line + 32, wrapped).
  - On pmem_resp: buf_data<=pmem_rdata, buf_tag<=pf_addr, buf_valid<=1, go to IDLE.
  - New cache requests are not accepted while in PREFETCH; they wait with mem_resp=0.
- mem_rdata is always driven from rdata_reg (registered) and is stable from the mem_resp cycle until the next read completes.
- pmem_read and pmem_write are never asserted together. Each is deasserted in the cycle after pmem_resp.
- mem_resp is never high for two consecutive cycles. The cache sees its own deassertion in the cycle after mem_resp; IDLE re-samples the request then.
- A pmem_resp arriving outside FETCH, WRITE or PREFETCH is ignored.

Test Plan:
- Cold read 0x00001234, pmem_resp after 3 cycles with data A:
  - pmem_read with pmem_address=0x00001220; mem_resp pulses once with mem_rdata=A.
  - Then pmem_read with 0x00001240; buffer loads data B.
- Streaming: after the previous scenario, read 0x00001248:
  - No pmem_read before mem_resp; mem_resp arrives one cycle after the request with mem_rdata=B.
  - Then prefetch of 0x00001260.
- Write invalidation: buffer holds 0x00001260; write 0x00001264 with data C:
  - pmem_write with 0x00001260 and pmem_wdata=C; buf_valid cleared.
  - A following read of 0x00001260 issues pmem_read (miss).
- Wrap: read 0xFFFFFFF0 → fetch 0xFFFFFFE0, then prefetch pmem_address=0x00000000. A read of 0x00000004 then hits in one cycle.
- Simultaneous mem_read and mem_write to 0x00002000: the write completes first (pmem_write, one mem_resp pulse), then the read is serviced.
- rst=0 mid-FETCH (pmem_read high): all outputs go to 0 asynchronously. After release, a read of the prefetched address misses (buf_valid=0).
- prefetch_en=0: a read of 0x00003000 completes and the FSM returns to IDLE. A read of 0x00003020 issues pmem_read.
